// File: rtl/lcd_history_bridge.sv
// Circular history of DIGITS-nibble timing records, two consecutive records
// rendered on a 2x16 LCD through the lcd_controller write_start/lcd_done handshake.
module lcd_history_bridge #(
   parameter int DIGITS       = 8,
   parameter int DEPTH        = 8,
   parameter int DELAY_CYCLES = 262142
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       insert,
   input  logic [4*DIGITS-1:0]        new_record,
   input  logic                       clear,
   input  logic                       scroll_up,
   input  logic                       scroll_down,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic [$clog2(DEPTH)-1:0]   view,
   output logic                       cmd_start,
   output logic                       cmd_rs,
   output logic [7:0]                 cmd_data,
   input  logic                       cmd_done
);

   localparam int LINE_CHARS   = DIGITS + DIGITS / 2 - 1;
   localparam int REFRESH_STEP = 4;
   localparam int LINE2_CMD    = REFRESH_STEP + 1 + LINE_CHARS;
   localparam int NUM_STEPS    = LINE2_CMD + 1 + LINE_CHARS;
   localparam int VW           = $clog2(DEPTH);
   localparam int SW           = $clog2(NUM_STEPS);
   localparam int DW           = $clog2(DELAY_CYCLES + 2);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, DELAY, NEXT} state_t;

   logic [4*DIGITS-1:0] mem [DEPTH];
   logic [VW-1:0]       head;
   logic [3:0]          lvl_q, lvl_qq, rise;
   logic                up_ok, dn_ok, hist_event;
   int                  view_i, count_i;

   state_t              state, state_nx;
   logic [SW-1:0]       step, step_nx;
   logic [DW-1:0]       dly, dly_nx;
   logic                start_nx, rs_nx, busy_nx;
   logic [7:0]          data_nx;
   logic                init_pending, refresh_pending, rp_nx;
   logic                take, init_done;
   logic                step_rs;
   logic [7:0]          step_byte;

   // bit 0 clear, bit 1 insert, bit 2 scroll_up, bit 3 scroll_down
   assign rise    = lvl_q & ~lvl_qq;
   assign view_i  = int'(view);
   assign count_i = int'(count);
   assign up_ok   = view_i + 2 < count_i;
   assign dn_ok   = view_i > 0;
   // Priority chain: a higher edge in the same cycle swallows the lower ones.
   assign hist_event = rise[0] | rise[1] | (rise[2] ? up_ok : (rise[3] & dn_ok));

   always_ff @(posedge clock) begin
      if (reset) begin
         lvl_q  <= '0;
         lvl_qq <= '0;
         head   <= '0;
         count  <= '0;
         view   <= '0;
      end else begin
         lvl_q  <= {scroll_down, scroll_up, insert, clear};
         lvl_qq <= lvl_q;
         if (rise[0]) begin
            head  <= '0;
            count <= '0;
            view  <= '0;
         end else if (rise[1]) begin
            head <= (int'(head) == DEPTH - 1) ? '0 : head + 1'b1;
            if (count_i != DEPTH)
               count <= count + 1'b1;
            view <= '0;
         end else if (rise[2]) begin
            if (up_ok)
               view <= view + 1'b1;
         end else if (rise[3]) begin
            if (dn_ok)
               view <= view - 1'b1;
         end
      end
   end

   // Record storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge clock) begin
      if (!reset && rise[1] && !rise[0])
         mem[head] <= new_record;
   end

   // Byte for the current step, read from live history at ISSUE time.
   always_comb begin
      int s, c, off, nib_pos;
      logic [VW-1:0]       rd_idx;
      logic [4*DIGITS-1:0] rec;
      logic [3:0]          nib;
      s         = int'(step);
      c         = 0;
      off       = 0;
      nib_pos   = 0;
      rd_idx    = '0;
      rec       = '0;
      nib       = '0;
      step_rs   = 1'b0;
      step_byte = 8'h00;
      if (s < REFRESH_STEP) begin
         case (s)
            0:       step_byte = 8'h38;
            1:       step_byte = 8'h0C;
            2:       step_byte = 8'h01;
            default: step_byte = 8'h06;
         endcase
      end else if (s == REFRESH_STEP) begin
         step_byte = 8'h80;
      end else if (s == LINE2_CMD) begin
         step_byte = 8'hC0;
      end else begin
         step_rs = 1'b1;
         if (s > LINE2_CMD) begin
            c   = s - LINE2_CMD - 1;
            off = view_i + 1;
         end else begin
            c   = s - REFRESH_STEP - 1;
            off = view_i;
         end
         rd_idx = VW'((int'(head) + 2 * DEPTH - 1 - off) % DEPTH);
         rec    = mem[rd_idx];
         if (off >= count_i) begin
            step_byte = 8'h20;
         end else if (c % 3 == 2) begin
            step_byte = (c == LINE_CHARS - 3) ? 8'h2E : 8'h3A;
         end else begin
            nib_pos   = DIGITS - 1 - (2 * (c / 3) + c % 3);
            nib       = rec[4*nib_pos +: 4];
            step_byte = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
         end
      end
   end

   always_comb begin
      state_nx  = state;
      step_nx   = step;
      dly_nx    = dly;
      start_nx  = cmd_start;
      rs_nx     = cmd_rs;
      data_nx   = cmd_data;
      take      = 1'b0;
      init_done = 1'b0;
      case (state)
         IDLE: begin
            if (init_pending || refresh_pending) begin
               state_nx = ISSUE;
               take     = 1'b1;
               step_nx  = init_pending ? '0 : SW'(REFRESH_STEP);
            end
         end
         ISSUE: begin
            state_nx = WAIT_DONE;
            start_nx = 1'b1;
            rs_nx    = step_rs;
            data_nx  = step_byte;
         end
         WAIT_DONE: begin
            if (cmd_done) begin
               start_nx = 1'b0;
               dly_nx   = '0;
               state_nx = DELAY;
            end
         end
         DELAY: begin
            if (int'(dly) + 1 >= DELAY_CYCLES)
               state_nx = NEXT;
            else
               dly_nx = dly + 1'b1;
         end
         NEXT: begin
            // Init is considered done once its last instruction has gone out.
            init_done = init_pending && (int'(step) == REFRESH_STEP - 1);
            if (refresh_pending) begin
               state_nx = ISSUE;
               take     = 1'b1;
               step_nx  = (init_pending && !init_done) ? '0 : SW'(REFRESH_STEP);
            end else if (int'(step) == NUM_STEPS - 1) begin
               state_nx = IDLE;
            end else begin
               state_nx = ISSUE;
               step_nx  = step + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
      // A (re)start always renders after this edge's history update, so it absorbs it.
      rp_nx   = take ? 1'b0 : (hist_event | refresh_pending);
      busy_nx = (state_nx != IDLE) | rp_nx;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= IDLE;
         step            <= '0;
         dly             <= '0;
         cmd_start       <= 1'b0;
         cmd_rs          <= 1'b0;
         cmd_data        <= 8'h00;
         busy            <= 1'b0;
         init_pending    <= 1'b1;
         refresh_pending <= 1'b0;
      end else begin
         state           <= state_nx;
         step            <= step_nx;
         dly             <= dly_nx;
         cmd_start       <= start_nx;
         cmd_rs          <= rs_nx;
         cmd_data        <= data_nx;
         busy            <= busy_nx;
         init_pending    <= init_pending & ~init_done;
         refresh_pending <= rp_nx;
      end
   end

endmodule

// File: tb/tb_lcd_history_bridge.sv
// Self-checking bench for lcd_history_bridge: random history events against a
// queue model of the history and of the expected LCD write stream.
module tb_lcd_history_bridge;
   localparam int DIGITS = 8;
   localparam int DEPTH  = 8;
   localparam int LC     = 11;

   logic        clock = 1'b0, reset = 1'b1;
   logic        insert = 1'b0, clear = 1'b0, scroll_up = 1'b0, scroll_down = 1'b0;
   logic        cmd_done = 1'b0;
   logic [31:0] new_record = '0;
   logic        busy, cmd_start, cmd_rs;
   logic [7:0]  cmd_data;
   logic [3:0]  count;
   logic [2:0]  view;

   int          n_chk = 0, n_fail = 0;
   logic [8:0]  wr_log[$];   // {rs,data} of every completed write
   logic [8:0]  exp_q[$];
   logic [8:0]  mid_q[$];
   logic [31:0] hist[$];     // newest first
   int          view_m = 0;
   string       hx = "0123456789ABCDEF";

   always #5 clock = ~clock;

   lcd_history_bridge #(.DIGITS(DIGITS), .DEPTH(DEPTH), .DELAY_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .insert(insert), .new_record(new_record),
      .clear(clear), .scroll_up(scroll_up), .scroll_down(scroll_down),
      .busy(busy), .count(count), .view(view), .cmd_start(cmd_start),
      .cmd_rs(cmd_rs), .cmd_data(cmd_data), .cmd_done(cmd_done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // lcd_controller stand-in: acknowledges 3 cycles after it sees cmd_start.
   initial begin : responder
      int cyc = 0;
      logic [8:0] held = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            cmd_done = 1'b0;
            cyc = 0;
         end else if (cmd_done) begin
            cmd_done = 1'b0;
         end else if (cmd_start) begin
            if (cyc == 0) held = {cmd_rs, cmd_data};
            else chk("cmd_stable", {cmd_rs, cmd_data}, held);
            cyc++;
            if (cyc == 3) begin
               cmd_done = 1'b1;
               cyc = 0;
               wr_log.push_back(held);
            end
         end
      end
   end

   task automatic push_line(input int off);
      logic [31:0] r;
      logic [7:0]  ch;
      if (off >= hist.size()) begin
         repeat (LC) exp_q.push_back({1'b1, 8'h20});
      end else begin
         r = hist[off];
         for (int k = DIGITS - 1; k >= 0; k--) begin
            ch = hx[r[4*k +: 4]];
            exp_q.push_back({1'b1, ch});
            if (k % 2 == 0 && k != 0) exp_q.push_back({1'b1, (k == 2) ? 8'h2E : 8'h3A});
         end
      end
   endtask

   task automatic build_refresh(input bit with_init);
      exp_q.delete();
      if (with_init) begin
         exp_q.push_back(9'h038);
         exp_q.push_back(9'h00C);
         exp_q.push_back(9'h001);
         exp_q.push_back(9'h006);
      end
      exp_q.push_back(9'h080);
      push_line(view_m);
      exp_q.push_back(9'h0C0);
      push_line(view_m + 1);
   endtask

   // mask: bit0 clear, bit1 insert, bit2 up, bit3 down; returns whether a refresh follows
   function automatic bit model_apply(input logic [3:0] m, input logic [31:0] rec);
      if (m[0]) begin
         hist.delete();
         view_m = 0;
         return 1'b1;
      end
      if (m[1]) begin
         hist.push_front(rec);
         if (hist.size() > DEPTH) void'(hist.pop_back());
         view_m = 0;
         return 1'b1;
      end
      if (m[2]) begin
         if (view_m + 2 < hist.size()) begin
            view_m++;
            return 1'b1;
         end
         return 1'b0;
      end
      if (m[3] && view_m > 0) begin
         view_m--;
         return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic pulse(input logic [3:0] m, input logic [31:0] rec);
      @(negedge clock);
      new_record = rec;
      {scroll_down, scroll_up, insert, clear} = m;
      repeat (2) @(negedge clock);
      {scroll_down, scroll_up, insert, clear} = 4'b0000;
      repeat (2) @(negedge clock);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      repeat (4) @(negedge clock);
      while ((busy || cmd_start) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      chk({tag, "_idle"}, {31'd0, busy | cmd_start}, 32'd0);
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_nwr"}, wr_log.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
         chk($sformatf("%s_wr%0d", tag, i), wr_log[i], exp_q[i]);
   endtask

   task automatic do_op(input string tag, input logic [3:0] m, input logic [31:0] rec);
      bit rf;
      wr_log.delete();
      pulse(m, rec);
      rf = model_apply(m, rec);
      wait_idle(tag);
      if (rf) build_refresh(1'b0);
      else exp_q.delete();
      check_log(tag);
      chk({tag, "_count"}, count, hist.size());
      chk({tag, "_view"}, view, view_m);
   endtask

   initial begin : main
      int n;
      int r;
      logic [3:0] m;
      repeat (3) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_start", cmd_start, 0);
      chk("rst_rs", cmd_rs, 0);
      chk("rst_data", cmd_data, 0);
      chk("rst_count", count, 0);
      chk("rst_view", view, 0);
      wr_log.delete();
      reset = 1'b0;
      wait_idle("init");
      build_refresh(1'b1);
      check_log("init");

      do_op("ins1", 4'b0010, 32'h12345678);
      do_op("ins2", 4'b0010, 32'h00000A5F);

      do_op("clr", 4'b0001, 32'h0);
      for (int i = 1; i <= 10; i++) do_op($sformatf("fill%0d", i), 4'b0010, i);
      chk("fill_count", count, 8);
      for (int i = 0; i < 8; i++) do_op($sformatf("up%0d", i), 4'b0100, 32'h0);
      chk("up_view", view, 6);
      do_op("down", 4'b1000, 32'h0);
      chk("down_view", view, 5);

      // clear lands while the 6th character write waits on cmd_done
      wr_log.delete();
      @(negedge clock);
      scroll_down = 1'b1;
      repeat (2) @(negedge clock);
      scroll_down = 1'b0;
      void'(model_apply(4'b1000, 32'h0));
      build_refresh(1'b0);
      mid_q = exp_q[0:6];
      n = 0;
      while (!(wr_log.size() == 6 && cmd_start && !cmd_done) && n < 2000) begin
         @(negedge clock);
         n++;
      end
      chk("mid_reach", wr_log.size(), 6);
      pulse(4'b0001, 32'h0);
      void'(model_apply(4'b0001, 32'h0));
      wait_idle("midclr");
      build_refresh(1'b0);
      exp_q = {mid_q, exp_q};
      check_log("midclr");
      chk("midclr_count", count, 0);
      chk("midclr_view", view, 0);

      do_op("pre", 4'b0010, 32'hCAFEF00D);
      do_op("insclr", 4'b0011, 32'h5A5A5A5A);

      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 19);
         if (r < 7) m = 4'b0010;
         else if (r < 12) m = 4'b0100;
         else if (r < 16) m = 4'b1000;
         else if (r == 16) m = 4'b0001;
         else m = 4'($urandom_range(1, 15));
         do_op($sformatf("rnd%0d", i), m, $urandom);
      end

      // reset while the third refresh write sits in its DELAY
      wr_log.delete();
      @(negedge clock);
      new_record = 32'h87654321;
      insert = 1'b1;
      repeat (2) @(negedge clock);
      insert = 1'b0;
      n = 0;
      while (!(wr_log.size() == 3 && !cmd_start) && n < 2000) begin
         @(negedge clock);
         n++;
      end
      chk("dly_reach", wr_log.size(), 3);
      reset = 1'b1;
      @(negedge clock);
      chk("rstmid_start", cmd_start, 0);
      chk("rstmid_busy", busy, 0);
      chk("rstmid_count", count, 0);
      hist.delete();
      view_m = 0;
      @(negedge clock);
      wr_log.delete();
      reset = 1'b0;
      wait_idle("reinit");
      build_refresh(1'b1);
      check_log("reinit");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
